// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state and PC-select encodings
// Contents:
//   INSTR_W, ADDR_W, IMEM_DEPTH : datapath widths and default program-store depth
//   NOP_INSTR                   : bubble encoding placed in IF/ID on reset
//   fetch_state_e               : fetch FSM states (run / halted)
//   pc_sel_e                    : next-PC source selection
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;
  localparam int IMEM_DEPTH = 128;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// rtl/if_stage_pc_reg.sv - program counter register with next-PC mux and range checks
// Ports:
//   clk, rst       : clock, synchronous active-high reset (pc <= RESET_PC)
//   sel_i          : next-PC source (hold / increment / load target)
//   target_i       : redirect word address
//   pc_o           : current PC (word address)
//   pc_last_o      : PC is at or beyond the last valid word, so an increment leaves the store
//   target_ok_o    : target_i lies inside the program store
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_last_o,
  output logic              target_ok_o
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = pc_q + 1'b1;
      PC_LOAD: pc_d = target_i;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

  // ">=" rather than "==" so a PC that somehow starts beyond the store still halts
  // on its next advance instead of running on.
  assign pc_last_o   = (pc_q >= LAST_A);
  assign target_ok_o = (target_i < DEPTH_A);

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IF/ID register, stall/flush/redirect, halt
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem_addr        : word address to instruction memory (combinational from pc)
//   imem_data        : instruction word returned combinationally by memory
//   stall            : hold pc and IF/ID this cycle
//   flush            : squash IF/ID valid
//   redirect_valid   : load pc from redirect_target (overrides stall)
//   redirect_target  : redirect word address
//   if_id_instr      : registered instruction
//   if_id_pc         : registered word address of if_id_instr
//   if_id_valid      : IF/ID holds a real instruction
//   halted           : fetch stopped because pc left the program store
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH    = IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  ipc_q;
  logic               valid_q;
  logic               halted_q;

  pc_sel_e            pc_sel;
  logic [ADDR_W-1:0]  pc;
  logic               pc_last;
  logic               target_ok;

  pc_reg #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .sel_i       (pc_sel),
    .target_i    (redirect_target),
    .pc_o        (pc),
    .pc_last_o   (pc_last),
    .target_ok_o (target_ok)
  );

  // In RUN a redirect always loads, even out of range, so pc shows where fetch
  // went off the end. In HALT only an in-range redirect restarts fetch.
  always_comb begin
    pc_sel = PC_HOLD;
    case (state_q)
      FETCH_RUN: begin
        if (redirect_valid) begin
          pc_sel = PC_LOAD;
        end else if (!stall) begin
          pc_sel = PC_INC;
        end
      end
      FETCH_HALT: begin
        if (redirect_valid && target_ok) begin
          pc_sel = PC_LOAD;
        end
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_RUN;
      instr_q  <= NOP_INSTR;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (redirect_valid) begin
            // The wrong-path word is still captured but marked as a bubble.
            instr_q <= imem_data;
            ipc_q   <= pc;
            valid_q <= 1'b0;
            if (!target_ok) begin
              state_q  <= FETCH_HALT;
              halted_q <= 1'b1;
            end
          end else if (stall) begin
            if (flush) begin
              valid_q <= 1'b0;
            end
          end else begin
            instr_q <= imem_data;
            ipc_q   <= pc;
            valid_q <= ~flush;
            // Last word is captured normally; the increment takes pc to DEPTH.
            if (pc_last) begin
              state_q  <= FETCH_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        FETCH_HALT: begin
          valid_q <= 1'b0;
          if (redirect_valid && target_ok) begin
            state_q  <= FETCH_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= FETCH_RUN;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (default depth and DEPTH=4)
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] a_addr, a_data, a_instr, a_ipc;
  logic        a_valid, a_halted;
  logic [31:0] b_addr, b_data, b_instr, b_ipc;
  logic        b_valid, b_halted;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a < 32'd256) return mem[a[7:0]];
    return 32'hFFFF_FFFF;
  endfunction

  assign a_data = mem_at(a_addr);
  assign b_data = mem_at(b_addr);

  if_stage #(.DEPTH(128), .RESET_PC(32'd0)) dut_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_data(a_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_id_instr(a_instr),
    .if_id_pc(a_ipc), .if_id_valid(a_valid), .halted(a_halted)
  );

  if_stage #(.DEPTH(4), .RESET_PC(32'd0)) dut_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_id_instr(b_instr),
    .if_id_pc(b_ipc), .if_id_valid(b_valid), .halted(b_halted)
  );

  // Architectural view of the fetch stage: where fetch is, what decode sees.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    bit          valid;
    bit          halted;
  } fetch_view_t;

  fetch_view_t ma, mb;

  function automatic fetch_view_t view_reset();
    fetch_view_t v;
    v.pc = 0; v.instr = 0; v.ipc = 0; v.valid = 0; v.halted = 0;
    return v;
  endfunction

  function automatic fetch_view_t advance(input fetch_view_t m, input longint depth,
                                          input bit r, input bit s, input bit f,
                                          input bit rv, input logic [31:0] rt);
    fetch_view_t n = m;
    if (r) return view_reset();
    if (m.halted) begin
      n.valid = 0;
      if (rv && longint'(rt) < depth) begin
        n.pc = rt;
        n.halted = 0;
      end
    end else if (rv) begin
      n.instr = mem_at(m.pc);
      n.ipc = m.pc;
      n.valid = 0;
      n.pc = rt;
      n.halted = (longint'(rt) >= depth);
    end else if (s) begin
      if (f) n.valid = 0;
    end else begin
      n.instr = mem_at(m.pc);
      n.ipc = m.pc;
      n.valid = !f;
      n.pc = m.pc + 1;
      n.halted = (longint'(m.pc) + 1 >= depth);
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_view(input string who, input fetch_view_t m,
                            input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] ipc, input logic valid, input logic hlt);
    check_eq({who, "_addr"}, addr, m.pc);
    check_eq({who, "_valid"}, 32'(valid), 32'(m.valid));
    check_eq({who, "_halted"}, 32'(hlt), 32'(m.halted));
    if (!m.halted) begin
      check_eq({who, "_instr"}, instr, m.instr);
      check_eq({who, "_ipc"}, ipc, m.ipc);
    end
  endtask

  // Apply one cycle of inputs, check both DUTs at the negative edge, advance models.
  task automatic tick(input bit r, input bit s, input bit f, input bit rv, input logic [31:0] rt);
    fetch_view_t na, nb;
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
    @(negedge clk);
    check_view("a", ma, a_addr, a_instr, a_ipc, a_valid, a_halted);
    check_view("b", mb, b_addr, b_instr, b_ipc, b_valid, b_halted);
    na = advance(ma, 128, r, s, f, rv, rt);
    nb = advance(mb, 4, r, s, f, rv, rt);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0109_4020;
    mem[1] = 32'h0109_5020;

    rst = 1'b1; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    repeat (2) @(posedge clk);
    #1;
    ma = view_reset();
    mb = view_reset();

    // Free run from reset: first words appear one edge after release.
    tick(0, 0, 0, 0, 0);
    check_eq("tp_w0_instr", a_instr, 32'h0109_4020);
    check_eq("tp_w0_pc", a_ipc, 32'd0);
    check_eq("tp_w0_valid", 32'(a_valid), 32'd1);
    check_eq("tp_addr1", a_addr, 32'd1);
    tick(0, 0, 0, 0, 0);
    check_eq("tp_w1_instr", a_instr, 32'h0109_5020);
    check_eq("tp_w1_pc", a_ipc, 32'd1);
    repeat (3) tick(0, 0, 0, 0, 0);
    check_eq("tp_b_halted", 32'(b_halted), 32'd1);
    check_eq("tp_b_pc4", b_addr, 32'd4);

    // Stall at pc=5 for three cycles.
    repeat (3) tick(0, 1, 0, 0, 0);
    check_eq("tp_stall_addr", a_addr, 32'd5);
    tick(0, 0, 0, 0, 0);
    check_eq("tp_w5_pc", a_ipc, 32'd5);
    check_eq("tp_pc6", a_addr, 32'd6);
    tick(0, 0, 0, 0, 0);

    // Stall + flush at pc=7.
    tick(0, 1, 1, 0, 0);
    check_eq("tp_sf_valid", 32'(a_valid), 32'd0);
    check_eq("tp_sf_addr", a_addr, 32'd7);
    repeat (2) tick(0, 0, 0, 0, 0);

    // Redirect to 20 at pc=9.
    tick(0, 0, 0, 1, 32'd20);
    check_eq("tp_rd_addr", a_addr, 32'd20);
    check_eq("tp_rd_valid", 32'(a_valid), 32'd0);
    tick(0, 0, 0, 0, 0);
    check_eq("tp_rd_ipc", a_ipc, 32'd20);
    check_eq("tp_rd_instr", a_instr, mem[20]);

    // Out-of-range redirect halts; stall/flush ignored in HALT.
    tick(0, 0, 0, 1, 32'd200);
    check_eq("tp_oob_halted", 32'(a_halted), 32'd1);
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);

    // Restart both from 0 by redirect.
    tick(0, 0, 0, 1, 32'd0);
    check_eq("tp_b_restart", 32'(b_halted), 32'd0);
    check_eq("tp_b_addr0", b_addr, 32'd0);
    repeat (6) tick(0, 0, 0, 0, 0);

    // Reset during HALT, then during a stall.
    tick(0, 0, 0, 1, 32'd300);
    tick(1, 0, 0, 0, 0);
    check_eq("tp_rst_halt", 32'(a_halted), 32'd0);
    check_eq("tp_rst_addr", a_addr, 32'd0);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    check_eq("tp_rst_stall_addr", a_addr, 32'd0);
    check_eq("tp_rst_stall_valid", 32'(a_valid), 32'd0);

    // Randomized traffic against the models.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0:       t = $urandom_range(0, 7);
        1, 2:    t = $urandom_range(0, 140);
        default: t = $urandom;
      endcase
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, t);
    end

    @(negedge clk);
    check_view("a", ma, a_addr, a_instr, a_ipc, a_valid, a_halted);
    check_view("b", mb, b_addr, b_instr, b_ipc, b_valid, b_halted);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
